// File: rtl/down_fifo_pkg.sv
// rtl/down_fifo_pkg.sv - shared types and constants for the downstream FIFO reader
package down_fifo_pkg;

    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Buffer entry layout, MSB first: {eof, sof, data}
    typedef struct packed {
        logic                  eof;
        logic                  sof;
        logic [DEF_DATA_W-1:0] data;
    } entry_t;

    function automatic int entry_width(input int data_w);
        return data_w + 2;
    endfunction

endpackage

// File: rtl/down_fifo_skid_buf.sv
// rtl/down_fifo_skid_buf.sv - small circular buffer hiding the FIFO read latency
module down_fifo_skid_buf #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       wr_dat,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       rd_dat,
    output logic [$clog2(DEPTH):0] occ
);

    localparam int PW = $clog2(DEPTH);
    localparam int OW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_wr;
    logic             do_rd;

    // A write into a full buffer is only taken when a read frees a slot in the same cycle
    assign do_rd = rd_en && (occ != '0);
    assign do_wr = wr_en && ((occ != OW'(DEPTH)) || do_rd);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (do_wr) begin
                mem[wr_ptr] <= wr_dat;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_wr, do_rd})
                2'b10:   occ <= occ + OW'(1);
                2'b01:   occ <= occ - OW'(1);
                default: occ <= occ;
            endcase
        end
    end

    assign rd_dat = mem[rd_ptr];

endmodule

// File: rtl/down_fifo_reader.sv
// rtl/down_fifo_reader.sv - credit-managed downstream FIFO reader producing framed stream words
module down_fifo_reader
    import down_fifo_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int RD_LATENCY = 1,
    parameter int BUF_DEPTH  = 4,
    parameter int FRAME_LEN  = 256
) (
    input  logic              clk_i,
    input  logic              reset_n_i,
    input  logic              enable_i,
    input  logic              fifo_empty_i,
    input  logic [DATA_W-1:0] fifo_dat_i,
    output logic              fifo_rd_o,
    output logic [DATA_W-1:0] tx_data_o,
    output logic              tx_valid_o,
    input  logic              tx_ready_i,
    output logic              tx_sof_o,
    output logic              tx_eof_o,
    output logic              busy_o,
    output logic [15:0]       frame_cnt_o,
    output logic [31:0]       word_cnt_o,
    output logic              ovf_err_o
);

    localparam int          EW       = entry_width(DATA_W);
    localparam int          OW       = $clog2(BUF_DEPTH) + 1;
    localparam int          LW       = $clog2(RD_LATENCY + 2);
    localparam logic [15:0] LAST_POS = 16'(FRAME_LEN - 1);
    localparam logic [OW-1:0] DEPTH_O = OW'(BUF_DEPTH);
    localparam logic [31:0] DEPTH_U  = 32'(BUF_DEPTH);

    state_t          state;
    logic [15:0]     rd_pos;
    logic [15:0]     rd_pos_nxt;
    logic [OW-1:0]   occ;
    logic [LW-1:0]   inflight;
    logic [EW-1:0]   head;
    logic            accept;
    logic            issue;
    logic            state_allows;
    logic            credit_ok;
    logic            at_last;
    logic            tag_sof;
    logic            tag_eof;
    logic            ret_v;
    logic            ret_sof;
    logic            ret_eof;

    assign tx_valid_o = (occ != '0);
    assign accept     = tx_valid_o && tx_ready_i;
    assign tx_data_o  = head[DATA_W-1:0];
    assign tx_sof_o   = tx_valid_o && head[DATA_W];
    assign tx_eof_o   = tx_valid_o && head[DATA_W+1];

    assign at_last      = (rd_pos == LAST_POS);
    assign tag_sof      = (rd_pos == 16'd0);
    assign tag_eof      = at_last;
    // DRAIN only finishes the frame already started; rd_pos==0 means it is complete
    assign state_allows = (state == ST_RUN) || ((state == ST_DRAIN) && (rd_pos != 16'd0));
    assign credit_ok    = (32'(occ) + 32'(inflight)) < (DEPTH_U + 32'(accept));
    assign issue        = state_allows && !fifo_empty_i && credit_ok;
    assign fifo_rd_o    = issue;

    assign busy_o = (state != ST_IDLE) || (occ != '0) || (inflight != '0);

    always_comb begin
        rd_pos_nxt = rd_pos;
        if (issue) begin
            rd_pos_nxt = at_last ? 16'd0 : rd_pos + 16'd1;
        end
    end

    if (RD_LATENCY == 0) begin : g_fwft
        assign ret_v    = issue;
        assign ret_sof  = tag_sof;
        assign ret_eof  = tag_eof;
        assign inflight = '0;
    end else begin : g_pipe
        logic [RD_LATENCY-1:0] pv;
        logic [RD_LATENCY-1:0] ps;
        logic [RD_LATENCY-1:0] pe;

        always_ff @(posedge clk_i or negedge reset_n_i) begin
            if (!reset_n_i) begin
                pv <= '0;
                ps <= '0;
                pe <= '0;
            end else begin
                pv[0] <= issue;
                ps[0] <= tag_sof;
                pe[0] <= tag_eof;
                for (int i = 1; i < RD_LATENCY; i++) begin
                    pv[i] <= pv[i-1];
                    ps[i] <= ps[i-1];
                    pe[i] <= pe[i-1];
                end
            end
        end

        always_comb begin
            inflight = '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                inflight = inflight + LW'(pv[i]);
            end
        end

        assign ret_v   = pv[RD_LATENCY-1];
        assign ret_sof = ps[RD_LATENCY-1];
        assign ret_eof = pe[RD_LATENCY-1];
    end

    down_fifo_skid_buf #(
        .WIDTH (EW),
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .wr_en     (ret_v),
        .wr_dat    ({ret_eof, ret_sof, fifo_dat_i}),
        .rd_en     (accept),
        .rd_dat    (head),
        .occ       (occ)
    );

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state       <= ST_IDLE;
            rd_pos      <= 16'd0;
            word_cnt_o  <= 32'd0;
            frame_cnt_o <= 16'd0;
            ovf_err_o   <= 1'b0;
        end else begin
            rd_pos <= rd_pos_nxt;
            if (accept) begin
                word_cnt_o <= word_cnt_o + 32'd1;
                if (tx_eof_o) begin
                    frame_cnt_o <= frame_cnt_o + 16'd1;
                end
            end
            if (ret_v && (occ == DEPTH_O) && !accept) begin
                ovf_err_o <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (enable_i) state <= ST_RUN;
                end
                ST_RUN: begin
                    if (!enable_i) state <= (rd_pos_nxt == 16'd0) ? ST_IDLE : ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (enable_i)                  state <= ST_RUN;
                    else if (rd_pos_nxt == 16'd0)  state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_down_fifo_reader.sv
// tb/tb_down_fifo_reader.sv - self-checking bench for down_fifo_reader
module tb_down_fifo_reader;

    localparam int FL  = 256;
    localparam int BUF = 4;

    typedef struct packed { logic [31:0] d; logic sof; logic eof; } item_t;
    typedef struct { logic [31:0] d; logic sof; logic eof; int cyc; } obs_t;
    typedef struct { int idx; logic [31:0] d; logic sof; logic eof; } vec_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic        fifo_empty = 1'b1;
    logic [31:0] fifo_dat = '0;
    logic        fifo_rd;
    logic [31:0] tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic        tx_sof, tx_eof, busy, ovf;
    logic [15:0] frame_cnt;
    logic [31:0] word_cnt;

    logic        enable1 = 1'b0;
    logic        fifo_empty1 = 1'b1;
    logic [31:0] fifo_dat1 = '0;
    logic        fifo_rd1;
    logic [31:0] tx_data1;
    logic        tx_valid1;
    logic        tx_ready1 = 1'b0;
    logic        tx_sof1, tx_eof1, busy1, ovf1;
    logic [15:0] frame_cnt1;
    logic [31:0] word_cnt1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int tb_pos = 0;
    int pops = 0;
    int acc_n = 0;
    int acc1 = 0;
    int first1 = 0;
    int last1 = 0;
    int rd_empty_viol = 0;
    int credit_viol = 0;
    int stab_viol = 0;
    int rd_cycles = 0;
    int eof_cyc = 0;
    bit eof_busy = 1'b0;
    bit rand_ready = 1'b0;
    bit prev_stall = 1'b0;
    bit acc_m;
    logic [33:0] prev_word = '0;
    logic [31:0] w, w1, e1;
    item_t e, ei;
    obs_t  g;

    item_t       sb[$];
    logic [31:0] sb1[$];
    logic [31:0] q[$];
    logic [31:0] q1[$];
    obs_t        got[$];
    vec_t        vt[7];

    down_fifo_reader dut (
        .clk_i(clk), .reset_n_i(reset_n), .enable_i(enable),
        .fifo_empty_i(fifo_empty), .fifo_dat_i(fifo_dat), .fifo_rd_o(fifo_rd),
        .tx_data_o(tx_data), .tx_valid_o(tx_valid), .tx_ready_i(tx_ready),
        .tx_sof_o(tx_sof), .tx_eof_o(tx_eof), .busy_o(busy),
        .frame_cnt_o(frame_cnt), .word_cnt_o(word_cnt), .ovf_err_o(ovf)
    );

    down_fifo_reader #(.RD_LATENCY(0), .FRAME_LEN(1)) dut1 (
        .clk_i(clk), .reset_n_i(reset_n), .enable_i(enable1),
        .fifo_empty_i(fifo_empty1), .fifo_dat_i(fifo_dat1), .fifo_rd_o(fifo_rd1),
        .tx_data_o(tx_data1), .tx_valid_o(tx_valid1), .tx_ready_i(tx_ready1),
        .tx_sof_o(tx_sof1), .tx_eof_o(tx_eof1), .busy_o(busy1),
        .frame_cnt_o(frame_cnt1), .word_cnt_o(word_cnt1), .ovf_err_o(ovf1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Standard FIFO model: data appears the cycle after the read strobe
    always @(posedge clk) begin
        if (fifo_rd && q.size() > 0) begin
            w = q.pop_front();
            fifo_dat <= w;
            ei.d   = w;
            ei.sof = (tb_pos == 0);
            ei.eof = (tb_pos == FL - 1);
            sb.push_back(ei);
            tb_pos = (tb_pos == FL - 1) ? 0 : tb_pos + 1;
            pops++;
        end
        fifo_empty <= (q.size() == 0);
    end

    // First-word-fall-through FIFO model for the zero-latency instance
    always @(posedge clk) begin
        if (fifo_rd1 && q1.size() > 0) begin
            w1 = q1.pop_front();
            sb1.push_back(w1);
        end
        fifo_dat1   <= (q1.size() > 0) ? q1[0] : 32'd0;
        fifo_empty1 <= (q1.size() == 0);
    end

    always begin
        @(posedge clk);
        #1;
        if (rand_ready) tx_ready = ($urandom_range(0, 99) >= 30);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        acc_m = tx_valid && tx_ready;
        if (fifo_rd && fifo_empty) rd_empty_viol++;
        if (fifo_rd && (sb.size() - (acc_m ? 1 : 0)) >= BUF) credit_viol++;
        if (prev_stall && (!tx_valid || {tx_eof, tx_sof, tx_data} != prev_word)) stab_viol++;
        prev_stall = tx_valid && !tx_ready;
        prev_word  = {tx_eof, tx_sof, tx_data};
        if (fifo_rd) rd_cycles++;
        if (acc_m) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_underflow: got word %0h expected none", tx_data);
            end else begin
                e = sb.pop_front();
                chk("sb_word", 64'({tx_eof, tx_sof, tx_data}), 64'({e.eof, e.sof, e.d}));
            end
            g.d = tx_data; g.sof = tx_sof; g.eof = tx_eof; g.cyc = cyc;
            got.push_back(g);
            acc_n++;
            if (tx_eof) begin
                eof_cyc  = cyc;
                eof_busy = busy;
            end
        end
    end

    always @(negedge clk) begin
        if (tx_valid1 && tx_ready1) begin
            if (sb1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL e_underflow: got word %0h expected none", tx_data1);
            end else begin
                e1 = sb1.pop_front();
                chk("e_word", 64'({tx_eof1, tx_sof1, tx_data1}), 64'({1'b1, 1'b1, e1}));
            end
            if (acc1 == 0) first1 = cyc;
            last1 = cyc;
            acc1++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        sb.delete(); got.delete(); q.delete();
        tb_pos = 0; acc_n = 0; pops = 0; prev_stall = 1'b0;
        tick(); tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic preload(input int first, input int last);
        for (int i = first; i <= last; i++) q.push_back(32'(i));
    endtask

    task automatic wait_acc(input int n, input int bound);
        for (int i = 0; i < bound && acc_n < n; i++) tick();
    endtask

    task automatic check_table(input string tag);
        for (int i = 0; i < 7; i++) begin
            logic [33:0] act;
            act = '0;
            if (vt[i].idx < got.size())
                act = {got[vt[i].idx].eof, got[vt[i].idx].sof, got[vt[i].idx].d};
            chk($sformatf("%s_word%0d", tag, vt[i].idx), 64'(act), 64'({vt[i].eof, vt[i].sof, vt[i].d}));
        end
    endtask

    initial begin
        int c0;
        logic [31:0] nxt;
        vt[0] = '{0,   32'h001, 1'b1, 1'b0};
        vt[1] = '{1,   32'h002, 1'b0, 1'b0};
        vt[2] = '{254, 32'h0ff, 1'b0, 1'b0};
        vt[3] = '{255, 32'h100, 1'b0, 1'b1};
        vt[4] = '{256, 32'h101, 1'b1, 1'b0};
        vt[5] = '{257, 32'h102, 1'b0, 1'b0};
        vt[6] = '{511, 32'h200, 1'b0, 1'b1};

        // Reset state
        tick(); tick();
        chk("rst_flags", 64'({fifo_rd, tx_valid, tx_sof, tx_eof, busy, ovf}), 64'(0));
        chk("rst_cnt", 64'({frame_cnt, word_cnt, tx_data}), 64'(0));
        chk("rst_flags1", 64'({fifo_rd1, tx_valid1, busy1, ovf1, frame_cnt1, word_cnt1}), 64'(0));
        reset_n = 1'b1;
        tick();

        // FRAME_LEN=1, zero read latency: five single-word frames back to back
        for (int i = 0; i < 5; i++) q1.push_back(32'hA0 + 32'(i));
        tick();
        tx_ready1 = 1'b1;
        enable1 = 1'b1;
        for (int i = 0; i < 100 && acc1 < 5; i++) tick();
        chk("E_words", 64'(acc1), 64'(5));
        chk("E_rate", 64'(last1 - first1), 64'(4));
        chk("E_frame_cnt", 64'(frame_cnt1), 64'(5));
        chk("E_word_cnt", 64'(word_cnt1), 64'(5));
        enable1 = 1'b0;
        repeat (4) tick();
        chk("E_idle", 64'({busy1, ovf1}), 64'(0));

        // Two full frames, ready held high
        do_reset();
        preload(1, 512);
        tick();
        tx_ready = 1'b1;
        enable = 1'b1;
        c0 = cyc;
        wait_acc(512, 3000);
        chk("A_words", 64'(acc_n), 64'(512));
        check_table("A");
        if (got.size() == 512) begin
            chk("A_first_lat", 64'(got[0].cyc - c0), 64'(3));
            chk("A_no_bubble", 64'(got[511].cyc - got[0].cyc), 64'(511));
        end
        chk("A_frame_cnt", 64'(frame_cnt), 64'(2));
        chk("A_word_cnt", 64'(word_cnt), 64'(512));
        enable = 1'b0;

        // Same stream under random backpressure
        do_reset();
        preload(1, 512);
        tick();
        rand_ready = 1'b1;
        enable = 1'b1;
        wait_acc(512, 6000);
        rand_ready = 1'b0;
        tick();
        tx_ready = 1'b1;
        chk("B_words", 64'(acc_n), 64'(512));
        check_table("B");
        chk("B_frame_cnt", 64'(frame_cnt), 64'(2));
        chk("B_word_cnt", 64'(word_cnt), 64'(512));
        chk("B_stable", 64'(stab_viol), 64'(0));
        chk("B_credit", 64'(credit_viol), 64'(0));
        chk("B_ovf", 64'(ovf), 64'(0));
        enable = 1'b0;

        // Enable dropped mid-frame: the frame is completed, then reads stop
        do_reset();
        preload(1, 300);
        tick();
        enable = 1'b1;
        for (int i = 0; i < 500 && pops < 100; i++) tick();
        enable = 1'b0;
        begin
            int fall;
            fall = -1;
            for (int i = 0; i < 1000; i++) begin
                tick();
                if (!busy) begin
                    fall = cyc;
                    break;
                end
            end
            chk("C_busy_fall", 64'(fall), 64'(eof_cyc + 1));
        end
        chk("C_busy_at_eof", 64'(eof_busy), 64'(1));
        repeat (20) tick();
        chk("C_pops", 64'(pops), 64'(256));
        chk("C_left", 64'(q.size()), 64'(44));
        chk("C_words", 64'(acc_n), 64'(256));
        chk("C_frame_cnt", 64'(frame_cnt), 64'(1));
        if (got.size() == 256) chk("C_last", 64'({got[255].eof, got[255].d}), 64'({1'b1, 32'h100}));

        // FIFO runs dry after 10 words and refills 50 cycles later
        do_reset();
        preload(1, 10);
        tick();
        enable = 1'b1;
        for (int i = 0; i < 200 && pops < 10; i++) tick();
        begin
            int rc;
            rc = rd_cycles;
            repeat (50) tick();
            chk("D_no_rd_empty", 64'(rd_cycles - rc), 64'(0));
        end
        preload(11, 256);
        wait_acc(256, 2000);
        chk("D_words", 64'(acc_n), 64'(256));
        if (got.size() == 256) begin
            chk("D_resume", 64'({got[10].sof, got[10].d}), 64'({1'b0, 32'd11}));
            chk("D_gap", 64'(got[10].cyc - got[9].cyc > 50), 64'(1));
            chk("D_close", 64'({got[255].eof, got[255].d}), 64'({1'b1, 32'd256}));
        end
        chk("D_frame_cnt", 64'(frame_cnt), 64'(1));
        chk("D_rd_empty", 64'(rd_empty_viol), 64'(0));
        enable = 1'b0;

        // Asynchronous reset mid-frame with reads in flight
        do_reset();
        preload(1, 300);
        tick();
        enable = 1'b1;
        wait_acc(20, 200);
        chk("F_pre_rd", 64'(fifo_rd), 64'(1));
        reset_n = 1'b0;
        #1;
        chk("F_rst_flags", 64'({fifo_rd, tx_valid, tx_sof, tx_eof, busy, ovf}), 64'(0));
        chk("F_rst_cnt", 64'({frame_cnt, word_cnt, tx_data}), 64'(0));
        nxt = q[0];
        sb.delete(); got.delete();
        tb_pos = 0; acc_n = 0; prev_stall = 1'b0;
        tick(); tick();
        reset_n = 1'b1;
        wait_acc(256, 2000);
        chk("F_words", 64'(acc_n), 64'(256));
        if (got.size() == 256) begin
            chk("F_first", 64'({got[0].sof, got[0].d}), 64'({1'b1, nxt}));
            chk("F_last", 64'({got[255].eof, got[255].d}), 64'({1'b1, nxt + 32'd255}));
        end
        chk("F_frame_cnt", 64'(frame_cnt), 64'(1));
        chk("F_word_cnt", 64'(word_cnt), 64'(256));
        chk("F_credit", 64'(credit_viol), 64'(0));
        chk("F_ovf", 64'(ovf), 64'(0));
        enable = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
